// File: rtl/sram_test_pkg.sv
// ============================================================================
//  Module : sram_test_pkg
//  Brief  : Op codes, FSM states and strobe polarity for the SRAM test controller.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_test_pkg;

    localparam logic [2:0] OP_R_ONE = 3'd0;
    localparam logic [2:0] OP_W_ONE = 3'd1;
    localparam logic [2:0] OP_FILL  = 3'd2;
    localparam logic [2:0] OP_DUMP  = 3'd3;
    localparam logic [2:0] OP_CHECK = 3'd4;

    // SRAM strobes are active low
    localparam logic ENA    = 1'b0;
    localparam logic DISENA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic op_is_sweep(input logic [2:0] op);
        return (op == OP_FILL) || (op == OP_DUMP) || (op == OP_CHECK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rd_pipe.sv
// ============================================================================
//  Module : sram_rd_pipe
//  Brief  : RD_LAT-deep valid/address delay line aligning read data capture.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_rd_pipe #(
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          o_valid,
    output logic [AW-1:0] o_addr
);

    logic [RD_LAT-1:0] r_vld;
    logic [AW-1:0]     r_addr [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_valid;
            r_addr[0] <= i_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_addr  = r_addr[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/sram_test_ctrl.sv
// ============================================================================
//  Module : sram_test_ctrl
//  Brief  : SRAM test controller: single read/write, fill, dump and check sweeps.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_test_ctrl
    import sram_test_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    input  logic          cmd_inv,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          half,
    output logic          done,
    output logic          err,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] err_addr,
    output logic          s_cen,
    output logic          s_wen,
    output logic          s_oen,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_ddata,
    input  logic [DW-1:0] s_qdata
);

    localparam int            DEPTH    = 2**AW;
    localparam int            LW       = $clog2(RD_LAT + 1);
    localparam logic [AW-1:0] c_LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_HALF   = AW'(DEPTH / 2 - 1);
    localparam logic [AW:0]   c_MAXCNT = (AW+1)'(DEPTH);

    state_e        r_state;
    state_e        w_next;
    logic [2:0]    r_op;
    logic [DW-1:0] r_data;
    logic          r_inv;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_lat;

    logic          w_accept;
    logic          w_last;
    logic          w_issue;
    logic          w_pipe_vld;
    logic [AW-1:0] w_pipe_addr;
    logic [DW-1:0] w_pat_wr;
    logic [DW-1:0] w_pat_chk;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign w_last    = !op_is_sweep(r_op) || (r_addr == c_LAST);
    assign w_issue   = (r_state == ST_WR) || (r_state == ST_RD);
    assign w_pat_wr  = (r_inv && r_addr[0])      ? ~r_data : r_data;
    assign w_pat_chk = (r_inv && w_pipe_addr[0]) ? ~r_data : r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_W_ONE, OP_FILL:           w_next = ST_WR;
                        OP_R_ONE, OP_DUMP, OP_CHECK: w_next = ST_RD;
                        default:                     w_next = ST_DONE;
                    endcase
                end
            end
            ST_WR:    if (w_last) w_next = ST_DONE;
            ST_RD:    if (w_last) w_next = ST_DRAIN;
            ST_DRAIN: if (r_lat == LW'(RD_LAT - 1)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        done      = (r_state == ST_DONE);
        s_cen     = w_issue              ? ENA : DISENA;
        s_wen     = (r_state == ST_WR)   ? ENA : DISENA;
        s_oen     = (r_state == ST_RD)   ? ENA : DISENA;
        s_addr    = r_addr;
        s_ddata   = (r_op == OP_W_ONE) ? r_data : w_pat_wr;
    end

    sram_rd_pipe #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (reset),
        .i_valid (r_state == ST_RD),
        .i_addr  (r_addr),
        .o_valid (w_pipe_vld),
        .o_addr  (w_pipe_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= '0;
            r_data    <= '0;
            r_inv     <= 1'b0;
            r_addr    <= '0;
            r_lat     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            half      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            err_addr  <= '0;
        end else begin
            out_valid <= w_pipe_vld;
            r_lat     <= (r_state == ST_DRAIN) ? r_lat + LW'(1) : '0;
            if (w_pipe_vld) begin
                out_data <= s_qdata;
                out_addr <= w_pipe_addr;
            end
            if (w_accept) begin
                r_op     <= cmd_op;
                r_data   <= cmd_data;
                r_inv    <= cmd_inv;
                r_addr   <= op_is_sweep(cmd_op) ? '0 : cmd_addr;
                half     <= 1'b0;
                err      <= (cmd_op > OP_CHECK);
                err_cnt  <= '0;
                err_addr <= '0;
            end else begin
                if (w_issue && !w_last) begin
                    r_addr <= r_addr + AW'(1);
                end
                // Fill progress follows issue; read sweeps follow capture
                if ((r_state == ST_WR) && (r_op == OP_FILL) && (r_addr == c_HALF)) begin
                    half <= 1'b1;
                end
                if (w_pipe_vld && op_is_sweep(r_op) && (w_pipe_addr == c_HALF)) begin
                    half <= 1'b1;
                end
                if (w_pipe_vld && (r_op == OP_CHECK) && (s_qdata != w_pat_chk)) begin
                    err <= 1'b1;
                    if (err_cnt != c_MAXCNT) begin
                        err_cnt <= err_cnt + (AW+1)'(1);
                    end
                    if (err_cnt == '0) begin
                        err_addr <= w_pipe_addr;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
